fir_mac_serial: RTL and testbench



---
 rtl/fir_mac_serial.sv | 108 ++++++++++
 tb/tb_fir_mac_serial.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_serial.sv
// fir_mac_serial: serial multiply-accumulate FIR engine.
// For each accepted sample the tap index walks 0..NTAPS-1. The index goes out
// to an external coefficient ROM, and the tap comes back in the same cycle.
// Each tap is accumulated against the matching delayed sample from a circular
// delay line. The full-precision result is offered on a valid/ready port.
module fir_mac_serial #(
  parameter int NTAPS  = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int IDX_W  = 5,
  parameter int ACC_W  = 36
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [IDX_W-1:0]         o_coef_idx,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [ACC_W-1:0]  o_data,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int PTR_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] line_q [NTAPS];
  logic [PTR_W-1:0]         wrPtr_q;
  logic [PTR_W-1:0]         k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  oData_q;
  logic                     oValid_q;

  logic [PTR_W-1:0]         rdPtr;
  logic signed [DATA_W-1:0] tapSample;
  logic signed [ACC_W-1:0]  coefExt;
  logic signed [ACC_W-1:0]  sampleExt;
  logic signed [ACC_W-1:0]  product;
  logic signed [ACC_W-1:0]  acc_d;

  // The newest sample sits at wrPtr_q and pairs with tap 0. Tap k reads
  // k entries back. The subtraction wraps naturally at PTR_W bits because
  // NTAPS is a power of two.
  assign rdPtr     = wrPtr_q - k_q;
  assign tapSample = line_q[rdPtr];
  assign coefExt   = {{(ACC_W-COEF_W){i_coef[COEF_W-1]}}, i_coef};
  assign sampleExt = {{(ACC_W-DATA_W){tapSample[DATA_W-1]}}, tapSample};
  assign product   = coefExt * sampleExt;
  assign acc_d     = acc_q + product;

  // Reset holds o_ready low. Otherwise the block is ready only when idle.
  assign o_ready    = (state_q == IDLE) && !i_rst;
  assign o_coef_idx = (state_q == MAC) ? IDX_W'(k_q) : '0;
  assign o_data     = oData_q;
  assign o_valid    = oValid_q;

  // Control FSM, delay line and accumulator. Reset discards any partial result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        line_q[i] <= '0;
      end
      wrPtr_q  <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      oData_q  <= '0;
      oValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && o_ready) begin
            line_q[wrPtr_q] <= i_data;
            acc_q           <= '0;
            k_q             <= '0;
            state_q         <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == PTR_W'(NTAPS - 1)) begin
            oData_q  <= acc_d;
            oValid_q <= 1'b1;
            wrPtr_q  <= wrPtr_q + PTR_W'(1);
            state_q  <= OUT;
          end else begin
            k_q <= k_q + PTR_W'(1);
          end
        end
        OUT: begin
          if (i_ready) begin
            oValid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: directed, table-driven bench for fir_mac_serial.
// A behavioural coefficient ROM answers o_coef_idx in the same cycle.
// Expected outputs are hand-computed sums of coef[k]*x[n-k].
module tb_fir_mac_serial;

  localparam int NTAPS  = 16;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int IDX_W  = 5;
  localparam int ACC_W  = 36;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_valid;
  logic                     o_ready;
  logic [IDX_W-1:0]         o_coef_idx;
  logic signed [COEF_W-1:0] i_coef;
  logic signed [ACC_W-1:0]  o_data;
  logic                     o_valid;
  logic                     i_ready;

  logic signed [COEF_W-1:0] rom [32];

  int total = 0;
  int bad   = 0;
  int lastCycles;
  logic [IDX_W-1:0] idxSeen [32];

  typedef struct {
    bit     doReset;
    int     romMode;
    longint x;
    longint expY;
  } vec_t;

  vec_t vecs [$];

  // Free-running clock with a 10 ns period.
  always #5 i_clk = ~i_clk;

  // The ROM behaves as combinational logic, so the tap follows the index in the same cycle.
  assign i_coef = rom[o_coef_idx];

  fir_mac_serial #(
    .NTAPS (NTAPS),
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .IDX_W (IDX_W),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_coef_idx(o_coef_idx),
    .i_coef    (i_coef),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Mode 0 sets every tap to 1, mode 1 sets every tap to 32767, and any other mode loads the ramp coef[k]=k.
  task automatic setRom(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       rom[i] = 16'sd1;
        1:       rom[i] = 16'sd32767;
        default: rom[i] = COEF_W'(i);
      endcase
    end
  endtask

  task automatic doReset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rstValid", longint'(o_valid), 0);
    checkOutput("rstData", longint'(o_data), 0);
    checkOutput("rstIdx", longint'(o_coef_idx), 0);
    checkOutput("rstReadyLow", longint'(o_ready), 0);
    i_rst = 1'b0;
    #1;
    checkOutput("rstReadyHigh", longint'(o_ready), 1);
  endtask

  // Offers one sample and waits for its result. i_ready is expected to be high.
  // lastCycles numbers the cycles after the accept edge, starting at 1.
  task automatic applyStimulus(input longint x, output longint y, output bit ok);
    int n;
    y       = 0;
    ok      = 1'b0;
    i_data  = DATA_W'(x);
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      checkOutput("acceptTimeout", 0, 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    n = 1;
    idxSeen[0] = o_coef_idx;
    while (!o_valid && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
      if (!o_valid && n <= 32) idxSeen[n-1] = o_coef_idx;
    end
    lastCycles = n;
    if (!o_valid) begin
      checkOutput("validTimeout", 0, 1);
      return;
    end
    y  = longint'($signed(o_data));
    ok = 1'b1;
  endtask

  // Watchdog that stops a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint y;
    bit     ok;
    int     n;
    bit     sawValid;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    setRom(0);

    // Impulse response with unit taps: 16 ones, then zeros.
    vecs.push_back('{1'b1, 0, 1, 1});
    for (int i = 0; i < 20; i++) vecs.push_back('{1'b0, 0, 0, (i < 15) ? 1 : 0});
    // A constant 100 stream ramps up to 1600 and holds there through the wr_ptr wrap.
    for (int i = 0; i < 20; i++) vecs.push_back('{i == 0, 0, 100, 100 * ((i < 16) ? i + 1 : 16)});
    // The extreme case 32767 * -32768 = -1073709056 per tap gives -17179344896 once the line is full.
    for (int i = 0; i < 18; i++)
      vecs.push_back('{i == 0, 1, -32768, -64'sd1073709056 * ((i < 16) ? i + 1 : 16)});
    // With ramp taps, the impulse sequence 0,1,...,15 and then 0 shows the tap/sample pairing order.
    vecs.push_back('{1'b1, 2, 1, 0});
    for (int i = 1; i <= 16; i++) vecs.push_back('{1'b0, 2, 0, (i < 16) ? i : 0});

    foreach (vecs[i]) begin
      if (vecs[i].doReset) begin
        doReset();
        setRom(vecs[i].romMode);
      end
      applyStimulus(vecs[i].x, y, ok);
      if (ok) checkOutput($sformatf("vec%0d", i), y, vecs[i].expY);
      if (i == 0) begin
        checkOutput("latency", lastCycles, 17);
        for (int k = 0; k < NTAPS; k++) checkOutput($sformatf("coefIdx%0d", k), longint'(idxSeen[k]), k);
      end
    end

    // Backpressure: the result is held while i_ready is low, and a pending sample waits.
    doReset();
    setRom(0);
    i_ready = 1'b0;
    i_data  = 16'sd5;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput("bpValidRise", longint'(o_valid), 1);
    i_data  = 16'sd77;
    i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("bpHoldValid%0d", c), longint'(o_valid), 1);
      checkOutput($sformatf("bpHoldData%0d", c), longint'($signed(o_data)), 5);
      checkOutput($sformatf("bpHoldReady%0d", c), longint'(o_ready), 0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("bpReleaseValid", longint'(o_valid), 0);
    checkOutput("bpReleaseReady", longint'(o_ready), 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput("bpAccepted", longint'(o_ready), 0);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput("bpSecondResult", longint'($signed(o_data)), 82);

    // A reset in the middle of MAC drops the partial result and clears the delay line.
    doReset();
    setRom(0);
    applyStimulus(3, y, ok);
    applyStimulus(4, y, ok);
    if (ok) checkOutput("midPrep", y, 7);
    i_data  = 16'sd9;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    n = 0;
    while (o_coef_idx != 5'd7 && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput("midMacIdx", longint'(o_coef_idx), 7);
    i_rst = 1'b1;
    #1;
    checkOutput("midRstReady", longint'(o_ready), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    checkOutput("midPostValid", longint'(o_valid), 0);
    checkOutput("midPostReady", longint'(o_ready), 1);
    sawValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) sawValid = 1'b1;
    end
    checkOutput("midNoEmit", longint'(sawValid), 0);
    applyStimulus(1, y, ok);
    if (ok) checkOutput("midImpulse0", y, 1);
    applyStimulus(0, y, ok);
    if (ok) checkOutput("midImpulse1", y, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
